// File: rtl/ecap5_dproc_pkg.sv
// Shared types and sizes for the execute-stage hazard/flush controller.
package ecap5_dproc_pkg;

    localparam int NB_REGS = 32;
    localparam int REG_AW  = $clog2(NB_REGS);

    typedef enum logic {HZD_IDLE, HZD_FLUSH} hzd_state_t;

endpackage

// File: rtl/hzd_counter.sv
// Pending-write counter for one architectural register.
// A writeback on an empty counter is dropped so the count never underflows.
module hzd_counter #(
    parameter int W = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic i_inc,
    input  logic i_dec,
    output logic o_zero,
    output logic o_max
);

    logic [W-1:0] r_cnt;
    logic         w_dec;

    assign w_dec = i_dec & (r_cnt != '0);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt <= '0;
        end else if (i_inc & !w_dec) begin
            r_cnt <= r_cnt + 1'b1;
        end else if (w_dec & !i_inc) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);
    assign o_max  = &r_cnt;

endmodule

// File: rtl/hzd.sv
// Hazard and flush controller beside the dec->exm->wbm pipeline: tracks in-flight
// register writes to stall decode on RAW hazards, and flushes ifm/dec on taken branches.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   HZD_IDLE  | normal operation, scoreboard tracks issues, stall allowed
//   HZD_FLUSH | front-end being discarded, issues ignored, stall forced 0
module hzd
    import ecap5_dproc_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int PENDING_W    = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              issue_valid_i,
    input  logic              issue_ready_i,
    input  logic              issue_write_i,
    input  logic [REG_AW-1:0] issue_addr_i,
    input  logic              rs1_used_i,
    input  logic [REG_AW-1:0] rs1_addr_i,
    input  logic              rs2_used_i,
    input  logic [REG_AW-1:0] rs2_addr_i,
    input  logic              wb_write_i,
    input  logic [REG_AW-1:0] wb_addr_i,
    input  logic              branch_valid_i,
    input  logic              branch_i,
    output logic              stall_o,
    output logic              flush_o
);

    localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FCW-1:0] FLUSH_LOAD = FCW'(FLUSH_CYCLES - 1);

    hzd_state_t         r_state;
    logic [FCW-1:0]     r_flush_cnt;
    logic               r_flush;

    logic               w_issue_wr;
    logic               w_taken;
    logic [NB_REGS-1:0] w_zero;
    logic [NB_REGS-1:0] w_max;

    assign w_issue_wr = issue_valid_i & issue_ready_i & issue_write_i & (r_state == HZD_IDLE);
    assign w_taken    = branch_valid_i & branch_i;

    // x0 is hardwired: always empty, never full, so it can never raise a hazard.
    assign w_zero[0] = 1'b1;
    assign w_max[0]  = 1'b0;

    for (genvar r = 1; r < NB_REGS; r++) begin : g_cnt
        hzd_counter #(
            .W (PENDING_W)
        ) u_cnt (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .i_inc  (w_issue_wr & (issue_addr_i == REG_AW'(r))),
            .i_dec  (wb_write_i & (wb_addr_i == REG_AW'(r))),
            .o_zero (w_zero[r]),
            .o_max  (w_max[r])
        );
    end

    // Counter state is used as-is: a same-cycle writeback does not bypass to decode.
    assign stall_o = (r_state == HZD_IDLE) &
                     ((rs1_used_i & !w_zero[rs1_addr_i]) |
                      (rs2_used_i & !w_zero[rs2_addr_i]) |
                      (issue_valid_i & issue_write_i & w_max[issue_addr_i]));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= HZD_IDLE;
            r_flush_cnt <= '0;
            r_flush     <= 1'b0;
        end else begin
            case (r_state)
                HZD_IDLE: begin
                    if (w_taken) begin
                        r_state     <= HZD_FLUSH;
                        r_flush_cnt <= FLUSH_LOAD;
                        r_flush     <= 1'b1;
                    end
                end
                HZD_FLUSH: begin
                    if (w_taken) begin
                        r_flush_cnt <= FLUSH_LOAD;
                    end else if (r_flush_cnt == '0) begin
                        r_state <= HZD_IDLE;
                        r_flush <= 1'b0;
                    end else begin
                        r_flush_cnt <= r_flush_cnt - 1'b1;
                    end
                end
            endcase
        end
    end

    assign flush_o = r_flush;

endmodule

// File: tb/tb_hzd.sv
// Directed bench for hzd: each step drives inputs, queues the expected stall/flush
// pair, then pops and checks it against the DUT outputs mid-cycle.
module tb_hzd;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       issue_valid_i, issue_ready_i, issue_write_i;
    logic [4:0] issue_addr_i;
    logic       rs1_used_i, rs2_used_i;
    logic [4:0] rs1_addr_i, rs2_addr_i;
    logic       wb_write_i;
    logic [4:0] wb_addr_i;
    logic       branch_valid_i, branch_i;
    logic       stall_o, flush_o;

    typedef struct {
        string tag;
        logic  stall;
        logic  flush;
    } exp_t;

    exp_t q_exp[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    hzd #(
        .FLUSH_CYCLES (2),
        .PENDING_W    (2)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .issue_valid_i  (issue_valid_i),
        .issue_ready_i  (issue_ready_i),
        .issue_write_i  (issue_write_i),
        .issue_addr_i   (issue_addr_i),
        .rs1_used_i     (rs1_used_i),
        .rs1_addr_i     (rs1_addr_i),
        .rs2_used_i     (rs2_used_i),
        .rs2_addr_i     (rs2_addr_i),
        .wb_write_i     (wb_write_i),
        .wb_addr_i      (wb_addr_i),
        .branch_valid_i (branch_valid_i),
        .branch_i       (branch_i),
        .stall_o        (stall_o),
        .flush_o        (flush_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic clr();
        issue_valid_i  = 1'b0;
        issue_ready_i  = 1'b0;
        issue_write_i  = 1'b0;
        issue_addr_i   = '0;
        rs1_used_i     = 1'b0;
        rs1_addr_i     = '0;
        rs2_used_i     = 1'b0;
        rs2_addr_i     = '0;
        wb_write_i     = 1'b0;
        wb_addr_i      = '0;
        branch_valid_i = 1'b0;
        branch_i       = 1'b0;
    endtask

    task automatic issue(input logic [4:0] a);
        issue_valid_i = 1'b1;
        issue_ready_i = 1'b1;
        issue_write_i = 1'b1;
        issue_addr_i  = a;
    endtask

    // Inputs are already driven (just after a falling edge); check, then advance.
    task automatic step(input string tag, input logic es, input logic ef);
        exp_t e;
        exp_t got;
        e.tag = tag;
        e.stall = es;
        e.flush = ef;
        q_exp.push_back(e);
        #1;
        got = q_exp.pop_front();
        n_assert++;
        assert (stall_o === got.stall) else begin
            n_fail++;
            $error("FAIL %s stall_o observed=%0b expected=%0b", got.tag, stall_o, got.stall);
        end
        n_assert++;
        assert (flush_o === got.flush) else begin
            n_fail++;
            $error("FAIL %s flush_o observed=%0b expected=%0b", got.tag, flush_o, got.flush);
        end
        @(negedge clk_i);
    endtask

    initial begin
        rst_i = 1'b0;
        clr();
        @(negedge clk_i);

        // reset held with random inputs
        for (int i = 0; i < 6; i++) begin
            issue_valid_i  = 1'($urandom);
            issue_ready_i  = 1'($urandom);
            issue_write_i  = 1'($urandom);
            issue_addr_i   = 5'($urandom);
            rs1_used_i     = 1'($urandom);
            rs1_addr_i     = 5'($urandom);
            rs2_used_i     = 1'($urandom);
            rs2_addr_i     = 5'($urandom);
            wb_write_i     = 1'($urandom);
            wb_addr_i      = 5'($urandom);
            branch_valid_i = 1'($urandom);
            branch_i       = 1'($urandom);
            step("reset_rand", 1'b0, 1'b0);
        end
        clr();
        rst_i = 1'b1;
        step("post_reset", 1'b0, 1'b0);

        // RAW on x5, no same-cycle wb bypass
        issue(5'd5);
        step("raw_issue", 1'b0, 1'b0);
        clr(); rs1_used_i = 1'b1; rs1_addr_i = 5'd5;
        step("raw_stall", 1'b1, 1'b0);
        wb_write_i = 1'b1; wb_addr_i = 5'd5;
        step("raw_wb_same", 1'b1, 1'b0);
        wb_write_i = 1'b0;
        step("raw_cleared", 1'b0, 1'b0);

        // x0 never hazards
        clr(); issue(5'd0);
        step("x0_issue", 1'b0, 1'b0);
        clr(); rs2_used_i = 1'b1; rs2_addr_i = 5'd0; rs1_used_i = 1'b1; rs1_addr_i = 5'd0;
        step("x0_read", 1'b0, 1'b0);

        // saturation of x7
        clr(); issue(5'd7);
        step("sat_issue1", 1'b0, 1'b0);
        step("sat_issue2", 1'b0, 1'b0);
        step("sat_issue3", 1'b0, 1'b0);
        issue_ready_i = 1'b0;
        step("sat_full", 1'b1, 1'b0);
        clr(); rs1_used_i = 1'b1; rs1_addr_i = 5'd7; wb_write_i = 1'b1; wb_addr_i = 5'd7;
        step("sat_wb1", 1'b1, 1'b0);
        step("sat_wb2", 1'b1, 1'b0);
        step("sat_wb3", 1'b1, 1'b0);
        step("sat_wb_empty", 1'b0, 1'b0);
        wb_write_i = 1'b0;
        step("sat_no_underflow", 1'b0, 1'b0);

        // flush window, stall masked, issue ignored, wb still counts
        clr(); issue(5'd3);
        step("fl_pre_issue", 1'b0, 1'b0);
        clr(); branch_valid_i = 1'b1; branch_i = 1'b1; rs1_used_i = 1'b1; rs1_addr_i = 5'd3;
        step("fl_branch", 1'b1, 1'b0);
        branch_valid_i = 1'b0; branch_i = 1'b0; issue(5'd9);
        step("fl_cyc1", 1'b0, 1'b1);
        issue_valid_i = 1'b0; wb_write_i = 1'b1; wb_addr_i = 5'd3;
        step("fl_cyc2", 1'b0, 1'b1);
        clr(); rs1_used_i = 1'b1; rs1_addr_i = 5'd9; rs2_used_i = 1'b1; rs2_addr_i = 5'd3;
        step("fl_after_x9_x3", 1'b0, 1'b0);
        clr(); branch_valid_i = 1'b1; branch_i = 1'b0;
        step("fl_not_taken", 1'b0, 1'b0);
        clr();
        step("fl_not_taken_nf", 1'b0, 1'b0);

        // back-to-back taken branches, then reset mid-flush
        issue(5'd4);
        step("b2b_issue_x4", 1'b0, 1'b0);
        clr(); branch_valid_i = 1'b1; branch_i = 1'b1;
        step("b2b_br1", 1'b0, 1'b0);
        clr();
        step("b2b_c1", 1'b0, 1'b1);
        branch_valid_i = 1'b1; branch_i = 1'b1;
        step("b2b_br2_last", 1'b0, 1'b1);
        clr();
        step("b2b_ext1", 1'b0, 1'b1);
        step("b2b_ext2", 1'b0, 1'b1);
        step("b2b_end", 1'b0, 1'b0);
        rs1_used_i = 1'b1; rs1_addr_i = 5'd4;
        step("b2b_x4_pending", 1'b1, 1'b0);
        clr(); branch_valid_i = 1'b1; branch_i = 1'b1;
        step("rst_br", 1'b0, 1'b0);
        clr();
        step("rst_fl1", 1'b0, 1'b1);
        rst_i = 1'b0; rs1_used_i = 1'b1; rs1_addr_i = 5'd4;
        step("rst_mid_flush", 1'b0, 1'b0);
        rst_i = 1'b1;
        step("rst_x4_cleared", 1'b0, 1'b0);
        step("rst_stay_idle", 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
